// File: rtl/parity_sched_pkg.sv
// Shared types and default sizing for the parity frame scheduler.
package parity_sched_pkg;

  localparam int unsigned DefNreq     = 4;
  localparam int unsigned DefFrameLen = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StReport
  } state_e;

endpackage

// File: rtl/serial_parity_core.sv
// Single-bit running XOR over a qualified serial stream; cleared at the start of each frame.
module serial_parity_core (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_valid,
  output logic parity
);

  logic parity_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (clear) begin
      parity_q <= 1'b0;
    end else if (bit_valid) begin
      parity_q <= parity_q ^ bit_in;
    end
  end

  assign parity = parity_q;

endmodule

// File: rtl/parity_frame_scheduler.sv
// Round-robin scheduler feeding NREQ requesters' frames LSB-first through one serial parity engine.
// Define PARITY_SCHED_ODD_EN to report odd parity instead of even; timing is unchanged.
module parity_frame_scheduler
  import parity_sched_pkg::*;
#(
  parameter int unsigned NREQ      = DefNreq,
  parameter int unsigned FRAME_LEN = DefFrameLen
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*FRAME_LEN-1:0]  frame_data,
  output logic [NREQ-1:0]            gnt,
  output logic                       busy,
  output logic                       ser_bit,
  output logic                       ser_valid,
  output logic                       done,
  output logic [$clog2(NREQ)-1:0]    done_id,
  output logic                       parity_out
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

  state_e               state_q, state_d;
  logic [IdW-1:0]       sel_q, last_q, rr_sel;
  logic                 rr_hit;
  int unsigned          rr_idx;
  logic [FRAME_LEN-1:0] shift_q;
  logic [CntW-1:0]      cnt_q;
  logic                 shift_last;
  logic                 parity_raw;
  logic                 parity_fmt;

  // Search starts one past the last served requester so a held request cannot starve others.
  always_comb begin
    rr_sel = '0;
    rr_hit = 1'b0;
    rr_idx = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      rr_idx = (32'(last_q) + off) % NREQ;
      if (!rr_hit && req[rr_idx[IdW-1:0]]) begin
        rr_hit = 1'b1;
        rr_sel = rr_idx[IdW-1:0];
      end
    end
  end

  assign shift_last = (state_q == StShift) && (cnt_q == CntW'(FRAME_LEN - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rr_hit) state_d = StLoad;
      StLoad:   state_d = StShift;
      StShift:  if (shift_last) state_d = StReport;
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q   <= '0;
      last_q  <= IdW'(NREQ - 1);
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == StIdle && rr_hit) begin
        sel_q <= rr_sel;
      end
      if (state_q == StLoad) begin
        shift_q <= frame_data[32'(sel_q) * FRAME_LEN +: FRAME_LEN];
        cnt_q   <= '0;
      end else if (state_q == StShift) begin
        shift_q <= shift_q >> 1;
        cnt_q   <= cnt_q + 1'b1;
      end
      // Only a completed frame counts as served; reset restores the initial priority.
      if (state_q == StReport) begin
        last_q <= sel_q;
      end
    end
  end

  always_comb begin
    gnt        = '0;
    busy       = (state_q != StIdle);
    ser_bit    = 1'b0;
    ser_valid  = 1'b0;
    done       = 1'b0;
    done_id    = '0;
    parity_out = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad:   gnt[sel_q] = 1'b1;
      StShift: begin
        ser_valid = 1'b1;
        ser_bit   = shift_q[0];
      end
      StReport: begin
        done       = 1'b1;
        done_id    = sel_q;
        parity_out = parity_fmt;
      end
      default: ;
    endcase
  end

  serial_parity_core u_core (
    .clock     (clock),
    .reset     (reset),
    .clear     (state_q == StLoad),
    .bit_in    (ser_bit),
    .bit_valid (ser_valid),
    .parity    (parity_raw)
  );

`ifdef PARITY_SCHED_ODD_EN
  assign parity_fmt = ~parity_raw;
`else
  assign parity_fmt = parity_raw;
`endif

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Bench for parity_frame_scheduler: directed scenarios plus random traffic against a frame-level model.
module tb_parity_frame_scheduler;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned IDW       = 2;
`ifdef PARITY_SCHED_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NREQ-1:0]           req;
  logic [NREQ*FRAME_LEN-1:0] frame_data;
  logic [NREQ-1:0]           gnt;
  logic                      busy, ser_bit, ser_valid, done, parity_out;
  logic [IDW-1:0]            done_id;

  always #5 clock = ~clock;

  parity_frame_scheduler #(
    .NREQ      (NREQ),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .frame_data (frame_data),
    .gnt        (gnt),
    .busy       (busy),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .done       (done),
    .done_id    (done_id),
    .parity_out (parity_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: a frame starts at the edge that finds the block idle with any request,
  // and everything else is a fixed offset from that start edge.
  int                   cyc;
  bit                   m_active;
  int                   m_start;
  int                   m_sel;
  int                   m_last;
  logic [FRAME_LEN-1:0] m_word;

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int off = 1; off <= NREQ; off++) begin
      if (r[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = NREQ - 1;
    m_sel    = 0;
    m_word   = '0;
  endtask

  task automatic model_edge();
    cyc++;
    if (reset) begin
      model_reset();
    end else if (!m_active) begin
      if (req != '0) begin
        m_sel    = rr_pick(m_last, req);
        m_start  = cyc;
        m_active = 1'b1;
      end
    end else begin
      if (cyc == m_start + 1) m_word = frame_data[m_sel*FRAME_LEN +: FRAME_LEN];
      if (cyc == m_start + FRAME_LEN + 2) begin
        m_active = 1'b0;
        m_last   = m_sel;
      end
    end
  endtask

  function automatic logic [31:0] model_out();
    int k;
    logic [NREQ-1:0] eg;
    logic sv, sb, dn, par;
    logic [IDW-1:0] id;
    eg = '0; sv = 1'b0; sb = 1'b0; dn = 1'b0; par = 1'b0; id = '0;
    if (m_active) begin
      k = cyc - m_start;
      if (k == 0) eg[m_sel] = 1'b1;
      if (k >= 1 && k <= FRAME_LEN) begin
        sv = 1'b1;
        sb = m_word[k-1];
      end
      if (k == FRAME_LEN + 1) begin
        dn  = 1'b1;
        id  = IDW'(m_sel);
        par = (^m_word) ^ ODD;
      end
    end
    return 32'({eg, m_active, sb, sv, dn, id, par});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({gnt, busy, ser_bit, ser_valid, done, done_id, parity_out});
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check($sformatf("cyc%0d", cyc), dut_vec(), model_out());
  endtask

  // Reset raised between edges must clear outputs without waiting for a clock.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_async", dut_vec(), 32'd0);
    step();
    step();
    reset = 1'b0;
  endtask

  logic [7:0] b5 = 8'hB5;
  int         ids[4], pars[4], dcyc[4];
  int         exp_par[4] = '{0, 0, 1, 0};
  int         nd, start, lat;
  logic [NREQ-1:0] grants[3];
  logic [NREQ-1:0] exp_gr[3] = '{4'b0001, 4'b0100, 4'b0001};
  logic [FRAME_LEN-1:0] w;

  initial begin
    reset = 1'b1; req = '0; frame_data = '0; cyc = 0;
    model_reset();
    step();
    step();
    reset = 1'b0;

    // Reset behaviour and quiet idle
    mid_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end

    // Single request, word B5 on requester 1
    frame_data = $urandom;
    frame_data[1*FRAME_LEN +: FRAME_LEN] = 8'hB5;
    req = 4'b0010;
    step();
    check("single_gnt", gnt, 4'b0010);
    step();
    req = '0;
    frame_data = $urandom;
    for (int i = 0; i < 8; i++) begin
      check("single_valid", ser_valid, 1);
      check("single_bit", ser_bit, b5[i]);
      step();
    end
    check("single_done", done, 1);
    check("single_id", done_id, 1);
    check("single_par", parity_out, 1 ^ ODD);
    step();
    check("single_idle", busy, 0);

    // Contention with all four requesters held
    mid_reset();
    frame_data = {8'h03, 8'h01, 8'hFF, 8'h00};
    req = 4'hF;
    nd = 0;
    for (int s = 0; s < 60 && nd < 4; s++) begin
      step();
      if (done) begin
        ids[nd] = done_id; pars[nd] = parity_out; dcyc[nd] = cyc;
        nd++;
      end
    end
    check("cont_count", nd, 4);
    for (int i = 0; i < nd; i++) begin
      check($sformatf("cont_id%0d", i), ids[i], i);
      check($sformatf("cont_par%0d", i), pars[i], exp_par[i] ^ ODD);
      if (i > 0) check($sformatf("cont_gap%0d", i), dcyc[i] - dcyc[i-1], 11);
    end
    req = '0;
    step();

    // Fairness: req0 held, req2 raised during frame 0
    req = 4'b0001;
    frame_data = $urandom;
    nd = 0;
    for (int s = 0; s < 50 && nd < 3; s++) begin
      step();
      if (gnt != '0) begin
        grants[nd] = gnt;
        nd++;
        req = 4'b0101;
      end
    end
    check("fair_count", nd, 3);
    for (int i = 0; i < nd; i++) check($sformatf("fair_gnt%0d", i), grants[i], exp_gr[i]);
    req = '0;
    for (int s = 0; s < 15 && busy; s++) step();
    check("fair_drain", busy, 0);

    // Reset abort in the 4th shift cycle, then the same word again
    w = FRAME_LEN'($urandom);
    frame_data = $urandom;
    frame_data[3*FRAME_LEN +: FRAME_LEN] = w;
    req = 4'b1000;
    for (int i = 0; i < 5; i++) step();
    check("abort_shifting", ser_valid, 1);
    mid_reset();
    start = cyc + 1;
    lat = -1;
    for (int s = 0; s < 20 && lat < 0; s++) begin
      step();
      if (done) begin
        lat = cyc - start;
        check("abort_par", parity_out, (^w) ^ ODD);
        check("abort_id", done_id, 3);
      end
    end
    // done is visible after the (FRAME_LEN+1)-th edge past the request edge
    check("abort_latency", lat, FRAME_LEN + 1);
    req = '0;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      req = ($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom);
      frame_data = $urandom;
      if ($urandom_range(0, 149) == 0) mid_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
